alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised multicycle ALU: the WIDTH-generic successor of the team's combinational 32-bit ALU. It adds subtraction, signed and unsigned compare, iterative shifts and an iterative multiply, plus full NZCV flags. Operands and results are carried on valid/ready handshakes. It sits between the register-read stage and write-back, and owns one operation at a time.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 4; SHW = $clog2(WIDTH)
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- in_op  in  4  opcode
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B; shifts use B[SHW-1:0] as shift amount
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_zero, out_neg, out_carry, out_ovf  out  1 each  flags Z, N, C, V

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT: signed A<B, result 1/0
  - 6 SLTU: unsigned A<B
  - 7 SLL
  - 8 SRL
  - 9 SRA
  - 10 MUL: low WIDTH bits of the unsigned product, shift-add
  - 11–15: result 0
- FSM states IDLE, BUSY, DONE.
  - Accept happens when in_valid && in_ready; in_op, in_a and in_b are captured on that edge. Input changes after accept are ignored.
  - IDLE → DONE on accept of ops 0–6, of ops 11–15, or of a shift with amount 0. The result is computed on the accept edge.
  - IDLE → BUSY on accept of a shift with amount n > 0 (n iterations) or of MUL (WIDTH iterations). Each BUSY cycle performs one iteration: a one-bit shift, or one add-and-shift step. The transition to DONE happens on the last iteration.
  - DONE → IDLE when out_ready is high. out_valid is high throughout DONE; result and flags are held stable until the handshake.
- Flags are computed from the final result:
  - Z = result == 0; N = result[WIDTH-1].
  - ADD: C = carry-out; V = signed overflow.
  - SUB: C = no-borrow (A ≥ B unsigned); V = signed overflow.
  - All other ops: C = 0, V = 0.
- SRA fills with the captured A[WIDTH-1]. SRL and SLL fill with 0. All arithmetic wraps modulo 2^WIDTH.

## Timing
- Reset values:
  - state IDLE
  - out_valid 0
  - out_result 0
  - all flags 0
  - internal counter and operand registers 0
- in_ready is high in the first cycle after reset deasserts. in_ready is decoded from the state (IDLE), so it is 0 during BUSY and DONE.
- Latency, counted from the accept edge until out_valid is high:
  - single-cycle ops and shift-by-0: 1 cycle
  - shift by n: n+1 cycles
  - MUL: WIDTH+1 cycles
- Throughput: the next accept is possible no earlier than the cycle after the DONE handshake. A back-to-back single-cycle op therefore issues every 2 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; the requester must hold its request until in_ready is high.
- Reset asserted in any state, including mid-BUSY: the operation is aborted with no out_valid pulse. All registers return to their reset values on that edge.
- Reset has priority over every simultaneous handshake.

## Test plan
- ADD, WIDTH=32: A=0x7FFFFFFF, B=1, out_ready=1 → out_valid 1 cycle after accept; result 0x80000000, N=1, V=1, C=0, Z=0. Then ADD A=0xFFFFFFFF, B=1 → result 0, Z=1, C=1, V=0.
- SUB/compare:
  - SUB 5−5 → 0, Z=1, C=1, V=0
  - SLT A=0xFFFFFFFF, B=1 → 1
  - SLTU with the same operands → 0, Z=1
  - opcode 13 → result 0, Z=1, C=0, V=0, latency 1
- Shifts:
  - SRA A=0x80000000, B=4 → 0xF8000000, out_valid 5 cycles after accept
  - SRL A=0x80000000, B=36 (amount 4) → 0x08000000
  - SLL A=1, B=0 → 1 with latency 1
- MUL A=0x00010003, B=0x00020005 → 0x000B000F, out_valid 33 cycles after accept, in_ready low throughout. MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Backpressure: finish an ADD with out_ready=0 for 3 cycles while in_valid=1 with a new op → result and flags stable, in_ready=0, no accept. out_ready=1 → IDLE next cycle, then the new op is accepted.
- Reset mid-MUL: assert reset at BUSY iteration 10 → out_valid never rises, in_ready=1 the cycle after reset drops. A following ADD 2+3 → 5 with latency 1.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes. Single-cycle ops finish on the
// accept edge. Shifts iterate one bit per cycle and MUL does one shift-add
// step per cycle, both driven by a down-counter.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | iterating a shift or multiply, one step per cycle
// DONE  | result and flags held, out_valid high until out_ready
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;

  logic [SHW-1:0]   amt;
  logic             is_shift, is_iter, accept;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] alu_res, step_a, step_acc;
  logic             alu_c, alu_v;

  assign amt      = in_b[SHW-1:0];
  assign is_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
  assign is_iter  = (in_op == OP_MUL) || (is_shift && (amt != '0));
  assign accept   = in_valid && (state_q == S_IDLE);

  // Registers: state, operands, counter, held result and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = is_iter ? S_BUSY : S_DONE;
      S_BUSY: if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU on the request operands
  always_comb begin
    add_full = {1'b0, in_a} + {1'b0, in_b};
    sub_full = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLL, OP_SRL, OP_SRA: alu_res = in_a;  // shift by zero
      default: alu_res = '0;
    endcase
  end

  // One iteration step of the captured shift or multiply
  always_comb begin
    step_a   = a_q;
    step_acc = acc_q;
    case (op_q)
      OP_SLL: step_a = {a_q[WIDTH-2:0], 1'b0};
      OP_SRL: step_a = {1'b0, a_q[WIDTH-1:1]};
      OP_SRA: step_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      OP_MUL: begin
        step_a   = {a_q[WIDTH-2:0], 1'b0};
        step_acc = b_q[0] ? (acc_q + a_q) : acc_q;
      end
      default: step_a = a_q;
    endcase
  end

  // Datapath register updates: capture on accept, iterate in BUSY
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (accept) begin
      op_d = in_op;
      if (is_iter) begin
        a_d   = in_a;
        b_d   = in_b;
        acc_d = '0;
        cnt_d = (in_op == OP_MUL) ? CW'(WIDTH) : {1'b0, amt};
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        neg_d    = alu_res[WIDTH-1];
        carry_d  = alu_c;
        ovf_d    = alu_v;
      end
    end else if (state_q == S_BUSY) begin
      a_d   = step_a;
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      acc_d = step_acc;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        result_d = (op_q == OP_MUL) ? step_acc : step_a;
        zero_d   = (result_d == '0);
        neg_d    = result_d[WIDTH-1];
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
      end
    end
  end

  // Outputs decoded from state and held registers
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_DONE);
    out_result = result_q;
    out_zero   = zero_q;
    out_neg    = neg_q;
    out_carry  = carry_q;
    out_ovf    = ovf_q;
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases plus
// randomized ops against an arithmetic reference model.
module tb_alu_multicycle;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_neg, out_carry, out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {result, Z, N, C, V}
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c, v;
    longint      sa, sb, s;
    logic [63:0] p;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      4'd0: begin
        r = a + b; c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << n;
      4'd8: r = a >> n;
      4'd9: r = 32'($signed(a) >>> n);
      4'd10: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      default: r = 32'd0;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'd10) return 33;
    if (op >= 4'd7 && op <= 4'd9) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one op with out_ready=1, check latency, busy in_ready, result, flags
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [35:0] exp;
    int lat;
    exp = model(op, a, b);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(model_lat(op, b)));
    chk({tag, ".result"}, 64'(out_result), 64'(exp[35:4]));
    chk({tag, ".flags"}, 64'({out_zero, out_neg, out_carry, out_ovf}), 64'(exp[3:0]));
    @(posedge clk); #1;
    chk({tag, ".release"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    logic [35:0] e;
    logic [31:0] held;
    logic [3:0]  hflags;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.outs", 64'({out_valid, out_result, out_zero, out_neg, out_carry, out_ovf}), 64'd0);
    @(negedge clk); reset = 1'b0;
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    // Directed
    do_op("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'd1);
    do_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'd1);
    do_op("sub_eq",   4'd1,  32'd5, 32'd5);
    do_op("slt",      4'd5,  32'hFFFF_FFFF, 32'd1);
    do_op("sltu",     4'd6,  32'hFFFF_FFFF, 32'd1);
    do_op("op13",     4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
    do_op("sra4",     4'd9,  32'h8000_0000, 32'd4);
    do_op("srl36",    4'd8,  32'h8000_0000, 32'd36);
    do_op("sll0",     4'd7,  32'd1, 32'd0);
    do_op("sll31",    4'd7,  32'd3, 32'd31);
    do_op("mul",      4'd10, 32'h0001_0003, 32'h0002_0005);
    do_op("mul_ff",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("sub_neg",  4'd1,  32'h8000_0000, 32'd1);

    // Backpressure: ADD held in DONE while a new SUB request waits
    @(negedge clk);
    in_op = 4'd0; in_a = 32'h8000_0000; in_b = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_op = 4'd1; in_a = 32'd3; in_b = 32'd7;
    e = model(4'd0, 32'h8000_0000, 32'h8000_0000);
    chk("bp.valid", 64'(out_valid), 64'd1);
    chk("bp.result", 64'(out_result), 64'(e[35:4]));
    chk("bp.flags", 64'({out_zero, out_neg, out_carry, out_ovf}), 64'(e[3:0]));
    held = out_result; hflags = {out_zero, out_neg, out_carry, out_ovf};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.hold", 64'({out_valid, in_ready, out_result, out_zero, out_neg, out_carry, out_ovf}),
          64'({1'b1, 1'b0, held, hflags}));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.idle", 64'({out_valid, in_ready}), 64'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = model(4'd1, 32'd3, 32'd7);
    chk("bp.next_valid", 64'(out_valid), 64'd1);
    chk("bp.next_result", 64'(out_result), 64'(e[35:4]));
    chk("bp.next_flags", 64'({out_zero, out_neg, out_carry, out_ovf}), 64'(e[3:0]));
    @(posedge clk); #1;

    // Reset in the middle of a MUL
    @(negedge clk);
    in_op = 4'd10; in_a = 32'h0000_1234; in_b = 32'h0000_5678; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      chk("rmul.busy", 64'({out_valid, in_ready}), 64'b00);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rmul.rst_outs", 64'({out_valid, out_result, out_zero, out_neg, out_carry, out_ovf}), 64'd0);
    @(negedge clk); reset = 1'b0;
    chk("rmul.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("rmul.no_valid", 64'(out_valid), 64'd0);
    end
    do_op("post_rst_add", 4'd0, 32'd2, 32'd3);

    // Randomized
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (($urandom & 3) == 0) ra = ($urandom & 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      if (($urandom & 3) == 0) rb = ra;
      do_op("rand", rop, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
